// File: rtl/fullsend_pkg.sv
// ---------------------------------------------------------------------------
// fullsend_pkg
// Shared definitions for the IF->ID decode stage:
//   - RV32 base opcode constants (OPC_*)
//   - imm_type_e : immediate format selected by the opcode
//   - id_state_e : occupancy state of the single-entry ID register
//   - helpers    : register-usage and supported-opcode predicates
// Optional feature macro used by consumers: DECODE_ILLEGAL_TRAP_EN
// ---------------------------------------------------------------------------
package fullsend_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    HOLD
  } id_state_e;

  // Every opcode reads rs1 except the ones that build a value from pc/imm only.
  function automatic logic uses_rs1(input logic [6:0] opc);
    return !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

  // Opcodes this pipeline implements; anything else is a candidate for a trap.
  function automatic logic opc_supported(input logic [6:0] opc);
    logic ok;
    case (opc)
      OPC_LOAD, OPC_OPIMM, OPC_STORE, OPC_OP, OPC_BRANCH,
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/inst_decode_stage_if.sv
// ---------------------------------------------------------------------------
// inst_decode_stage_if
// Bundles the fetch handshake, the EX-side controls and the decoded ID fields.
//   master : fetch/EX/control-unit side (drives if_*, flush, ex_*)
//   slave  : the decode stage (drives if_ready, id_*, decoded fields, stall)
// Signals:
//   if_valid/if_inst/if_pc/if_ready : fetch handshake
//   flush                           : kill held instruction (branch redirect)
//   ex_ready, ex_load_valid/rd      : EX consume strobe and load-use info
//   id_valid, id_pc, current_opcode, current_func, rs1, rs2, rd, imm, stall
//   illegal (only with DECODE_ILLEGAL_TRAP_EN defined)
// ---------------------------------------------------------------------------
interface inst_decode_stage_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic [31:0]     if_inst;
  logic [XLEN-1:0] if_pc;
  logic            if_ready;
  logic            flush;
  logic            ex_ready;
  logic            ex_load_valid;
  logic [4:0]      ex_load_rd;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [6:0]      current_opcode;
  logic [3:0]      current_func;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm;
  logic            stall;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic            illegal;
`endif

  modport master (
    output if_valid, if_inst, if_pc, flush, ex_ready, ex_load_valid, ex_load_rd,
`ifdef DECODE_ILLEGAL_TRAP_EN
    input  illegal,
`endif
    input  if_ready, id_valid, id_pc, current_opcode, current_func,
           rs1, rs2, rd, imm, stall
  );

  modport slave (
    input  if_valid, if_inst, if_pc, flush, ex_ready, ex_load_valid, ex_load_rd,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output illegal,
`endif
    output if_ready, id_valid, id_pc, current_opcode, current_func,
           rs1, rs2, rd, imm, stall
  );

endinterface

// File: rtl/imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen
// Combinational immediate extractor for RV32 base instructions.
// Ports:
//   inst_i     in  32    instruction word
//   imm_type_o out  3    immediate format chosen from inst_i[6:2]
//   imm_o      out XLEN  immediate, sign-extended from inst_i[31]
// ---------------------------------------------------------------------------
module imm_gen
  import fullsend_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output imm_type_e       imm_type_o,
  output logic [XLEN-1:0] imm_o
);

  logic [4:0] opc_hi;
  logic       sign;
  // The format is keyed on opcode[6:2]; the length bits [1:0] do not matter here.
  logic       unused_len_bits;

  assign opc_hi          = inst_i[6:2];
  assign sign            = inst_i[31];
  assign unused_len_bits = ^inst_i[1:0];

  always_comb begin
    imm_type_o = IMM_NONE;
    if (opc_hi == OPC_LOAD[6:2] || opc_hi == OPC_OPIMM[6:2] || opc_hi == OPC_JALR[6:2])
      imm_type_o = IMM_I;
    else if (opc_hi == OPC_STORE[6:2])
      imm_type_o = IMM_S;
    else if (opc_hi == OPC_BRANCH[6:2])
      imm_type_o = IMM_B;
    else if (opc_hi == OPC_LUI[6:2] || opc_hi == OPC_AUIPC[6:2])
      imm_type_o = IMM_U;
    else if (opc_hi == OPC_JAL[6:2])
      imm_type_o = IMM_J;
  end

  always_comb begin
    imm_o = '0;
    case (imm_type_o)
      IMM_I: imm_o = {{(XLEN-11){sign}}, inst_i[30:20]};
      IMM_S: imm_o = {{(XLEN-11){sign}}, inst_i[30:25], inst_i[11:7]};
      IMM_B: imm_o = {{(XLEN-12){sign}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      IMM_U: imm_o = {{(XLEN-31){sign}}, inst_i[30:12], 12'b0};
      IMM_J: imm_o = {{(XLEN-20){sign}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/inst_decode_stage.sv
// ---------------------------------------------------------------------------
// inst_decode_stage
// Single-entry IF->ID pipeline register with field extraction. Captures one
// fetched instruction per valid/ready handshake, presents the decoded fields
// to the control unit and EX, and inserts a bubble on a load-use hazard
// (the control unit only learns about the load one cycle late).
// Ports:
//   clk    in  clock, all state updates on posedge
//   reset  in  asynchronous active-high reset, clears all state
//   bus    slave modport of inst_decode_stage_if (fetch handshake, flush,
//          EX controls, decoded outputs, stall)
// Optional feature: DECODE_ILLEGAL_TRAP_EN adds the registered bus.illegal
// flag (set for non-32-bit encodings or unsupported opcodes; id_valid still
// asserts so EX can raise the trap). Without it such instructions pass
// through untouched.
// ---------------------------------------------------------------------------
module inst_decode_stage
  import fullsend_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  inst_decode_stage_if.slave  bus
);

  id_state_e       state_q, state_d;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] pc_q;

  logic       hazard;
  logic       accept;
  logic       if_ready_c;
  logic       id_valid_c;
  logic       stall_c;
  logic [6:0] opc;
  logic [4:0] rs1_f, rs2_f, rd_f;
  logic [2:0] funct3;
  logic       func_hi;

  imm_type_e       imm_type;
  logic [XLEN-1:0] imm_w;
  // Format tag is only useful for debug visibility; the stage exports imm itself.
  logic            unused_imm_type;

  // ---------------- field extraction on the held instruction ----------------
  assign opc    = inst_q[6:0];
  assign rd_f   = inst_q[11:7];
  assign funct3 = inst_q[14:12];
  assign rs1_f  = inst_q[19:15];
  assign rs2_f  = inst_q[24:20];

  // inst[30] distinguishes SUB/SRA/SRAI; for every other opcode it is
  // immediate data and must not leak into the function code.
  assign func_hi = inst_q[30] & ((opc == OPC_OP) ||
                                 ((opc == OPC_OPIMM) && (funct3 == 3'b101)));

  imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .inst_i    (inst_q),
    .imm_type_o(imm_type),
    .imm_o     (imm_w)
  );

  assign unused_imm_type = ^imm_type;

  // ---------------- hazard detection ----------------
  // x0 never carries a dependency, so a load to x0 cannot stall.
  assign hazard = (state_q == FULL) && bus.ex_load_valid && (bus.ex_load_rd != 5'd0) &&
                  ((uses_rs1(opc) && (rs1_f == bus.ex_load_rd)) ||
                   (uses_rs2(opc) && (rs2_f == bus.ex_load_rd)));

  assign accept = bus.if_valid && if_ready_c;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) state_d = FULL;
        end
        FULL: begin
          if (hazard)            state_d = HOLD;
          else if (bus.ex_ready) state_d = accept ? FULL : EMPTY;
        end
        HOLD:    state_d = FULL;
        default: state_d = EMPTY;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    id_valid_c = 1'b0;
    stall_c    = 1'b0;
    if_ready_c = 1'b0;
    case (state_q)
      EMPTY: begin
        if_ready_c = 1'b1;
      end
      FULL: begin
        id_valid_c = !hazard;
        stall_c    = hazard;
        // Accept only when the current entry leaves this cycle: consume-and-refill.
        if_ready_c = !hazard && bus.ex_ready;
      end
      HOLD: begin
        stall_c = 1'b1;
      end
      default: begin
        id_valid_c = 1'b0;
      end
    endcase
    // A redirect kills the cycle; nothing may be captured behind it.
    if (bus.flush) if_ready_c = 1'b0;
  end

  // ---------------- instruction / pc register ----------------
  // Fields are deliberately left stale on flush; id_valid qualifies them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_q <= '0;
      pc_q   <= '0;
    end else if (accept) begin
      inst_q <= bus.if_inst;
      pc_q   <= bus.if_pc;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if (accept) begin
      illegal_q <= (bus.if_inst[1:0] != 2'b11) || !opc_supported(bus.if_inst[6:0]);
    end
  end

  assign bus.illegal = illegal_q;
`endif

  // ---------------- outputs ----------------
  assign bus.if_ready       = if_ready_c;
  assign bus.id_valid       = id_valid_c;
  assign bus.stall          = stall_c;
  assign bus.id_pc          = pc_q;
  assign bus.current_opcode = opc;
  assign bus.current_func   = {func_hi, funct3};
  assign bus.rs1            = rs1_f;
  assign bus.rs2            = rs2_f;
  assign bus.rd             = rd_f;
  assign bus.imm            = imm_w;

endmodule
